// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared UART constants and helpers for the RX buffer path.
//   UART_DATA_W           : default payload width
//   UART_RX_FIFO_DEPTH    : default RX FIFO depth (power of two, >= 4)
//   UART_RX_FIFO_AF_LEVEL : default almost-full threshold (count >= level)
//   UART_RX_FIFO_AE_LEVEL : default almost-empty threshold (count <= level)
//   fifo_cnt_w()          : pointer/count width for a given depth
//   fifo_flags_t          : bundle of the occupancy status flags
// -----------------------------------------------------------------------------
package uart_pkg;

  localparam int UART_DATA_W           = 8;
  localparam int UART_RX_FIFO_DEPTH    = 32;
  localparam int UART_RX_FIFO_AF_LEVEL = 28;
  localparam int UART_RX_FIFO_AE_LEVEL = 4;

  // One extra bit beyond the address so full and empty are distinguishable
  // from the pointers alone.
  function automatic int fifo_cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
  } fifo_flags_t;

endpackage

// File: rtl/uart_rx_fifo_ctl_if.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo_ctl_if
// Bus bundle between the RX deserialiser / register interface (master) and the
// RX FIFO controller (slave).
//   master drives : flush, wr_en, wr_data, rd_en, err_clr (+ wr_err)
//   slave drives  : rd_data, full, empty, almost_full, almost_empty, count,
//                   overflow, underflow (+ rd_err)
// Optional macro UART_RX_FIFO_ERR_TAG_EN adds the per-entry error tag
// signals wr_err / rd_err.
// -----------------------------------------------------------------------------
interface uart_rx_fifo_ctl_if
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = UART_DATA_W,
  parameter int CNT_W      = fifo_cnt_w(UART_RX_FIFO_DEPTH)
);

  logic                  flush;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [CNT_W-1:0]      count;
  logic                  overflow;
  logic                  underflow;
  logic                  err_clr;
`ifdef UART_RX_FIFO_ERR_TAG_EN
  logic                  wr_err;
  logic                  rd_err;
`endif

`ifdef UART_RX_FIFO_ERR_TAG_EN
  modport master (
    output flush, wr_en, wr_data, wr_err, rd_en, err_clr,
    input  rd_data, rd_err, full, empty, almost_full, almost_empty, count,
           overflow, underflow
  );
  modport slave (
    input  flush, wr_en, wr_data, wr_err, rd_en, err_clr,
    output rd_data, rd_err, full, empty, almost_full, almost_empty, count,
           overflow, underflow
  );
`else
  modport master (
    output flush, wr_en, wr_data, rd_en, err_clr,
    input  rd_data, full, empty, almost_full, almost_empty, count,
           overflow, underflow
  );
  modport slave (
    input  flush, wr_en, wr_data, rd_en, err_clr,
    output rd_data, full, empty, almost_full, almost_empty, count,
           overflow, underflow
  );
`endif

endinterface

// File: rtl/uart_fifo_mem.sv
// -----------------------------------------------------------------------------
// uart_fifo_mem
// Simple dual-port register array: synchronous write, asynchronous read.
// Contents are deliberately not reset.
//   clk   : write clock
//   we    : write enable
//   waddr : write address
//   wdata : write word
//   raddr : read address
//   rdata : read word (combinational from raddr)
// -----------------------------------------------------------------------------
module uart_fifo_mem #(
  parameter int W     = 8,
  parameter int AW    = 5,
  parameter int DEPTH = 32
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_fifo_ctl.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo_ctl
// UART RX receive FIFO: pointer/count/flag control around uart_fifo_mem.
//   clk  : clock, rising edge
//   rstn : asynchronous active-low reset
//   bus  : uart_rx_fifo_ctl_if.slave
//          flush / err_clr      synchronous clear of contents / sticky errors
//          wr_en, wr_data       write side (deserialiser)
//          rd_en, rd_data       read side (standard or FWFT per FWFT param)
//          full, empty, almost_full, almost_empty, count
//          overflow, underflow  sticky error flags
// Optional macro UART_RX_FIFO_ERR_TAG_EN: stores a per-entry error bit
// (wr_err in, rd_err out) that tracks rd_data timing exactly.
// -----------------------------------------------------------------------------
module uart_rx_fifo_ctl
  import uart_pkg::*;
#(
  parameter  int DATA_WIDTH = UART_DATA_W,
  parameter  int DEPTH      = UART_RX_FIFO_DEPTH,
  parameter  int AF_LEVEL   = UART_RX_FIFO_AF_LEVEL,
  parameter  int AE_LEVEL   = UART_RX_FIFO_AE_LEVEL,
  parameter  int FWFT       = 0,
  localparam int CNT_W      = fifo_cnt_w(DEPTH)
) (
  input logic               clk,
  input logic               rstn,
  uart_rx_fifo_ctl_if.slave bus
);

  localparam int AW = CNT_W - 1;
`ifdef UART_RX_FIFO_ERR_TAG_EN
  localparam int MW = DATA_WIDTH + 1;
`else
  localparam int MW = DATA_WIDTH;
`endif

  logic [CNT_W-1:0] wr_ptr, rd_ptr, cnt;
  logic [CNT_W-1:0] wr_ptr_nxt, rd_ptr_nxt;
  logic             wr_acc, rd_acc, ov_ev, un_ev;
  logic             ovf, unf;
  logic [MW-1:0]    wword, mword, rword;
  fifo_flags_t      flg;

  // Flags decode from registered state only, so they show the post-edge view.
  always_comb begin
    flg.empty        = (wr_ptr == rd_ptr);
    flg.full         = (wr_ptr[AW] != rd_ptr[AW]) &&
                       (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    flg.almost_full  = (cnt >= CNT_W'(AF_LEVEL));
    flg.almost_empty = (cnt <= CNT_W'(AE_LEVEL));
  end

  // flush swallows both requests; a full FIFO refuses writes even when a read
  // frees a slot in the same cycle.
  assign wr_acc = bus.wr_en && !flg.full  && !bus.flush;
  assign rd_acc = bus.rd_en && !flg.empty && !bus.flush;
  assign ov_ev  = bus.wr_en &&  flg.full  && !bus.flush;
  assign un_ev  = bus.rd_en &&  flg.empty && !bus.flush;

  always_comb begin
    wr_ptr_nxt = wr_ptr + CNT_W'(wr_acc);
    rd_ptr_nxt = rd_ptr + CNT_W'(rd_acc);
    if (bus.flush) begin
      wr_ptr_nxt = '0;
      rd_ptr_nxt = '0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      ovf    <= 1'b0;
      unf    <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr_nxt;
      rd_ptr <= rd_ptr_nxt;
      // Registered copy of the pointer difference, updated with the pointers.
      cnt    <= wr_ptr_nxt - rd_ptr_nxt;
      // A new event outranks err_clr in the same cycle.
      ovf    <= (ovf && !bus.err_clr) || ov_ev;
      unf    <= (unf && !bus.err_clr) || un_ev;
    end
  end

`ifdef UART_RX_FIFO_ERR_TAG_EN
  assign wword = {bus.wr_err, bus.wr_data};
`else
  assign wword = bus.wr_data;
`endif

  uart_fifo_mem #(
    .W     (MW),
    .AW    (AW),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (wword),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (mword)
  );

  generate
    if (FWFT != 0) begin : g_fwft
      // Head of queue presented directly. Forced to zero while empty so the
      // output is deterministic out of reset (it is don't-care there anyway).
      assign rword = flg.empty ? '0 : mword;
    end else begin : g_std
      logic [MW-1:0] rd_q;
      // Only an accepted read loads the register; flush leaves it untouched.
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)       rd_q <= '0;
        else if (rd_acc) rd_q <= mword;
      end
      assign rword = rd_q;
    end
  endgenerate

  assign bus.rd_data      = rword[DATA_WIDTH-1:0];
`ifdef UART_RX_FIFO_ERR_TAG_EN
  assign bus.rd_err       = rword[DATA_WIDTH];
`endif
  assign bus.full         = flg.full;
  assign bus.empty        = flg.empty;
  assign bus.almost_full  = flg.almost_full;
  assign bus.almost_empty = flg.almost_empty;
  assign bus.count        = cnt;
  assign bus.overflow     = ovf;
  assign bus.underflow    = unf;

  a_cnt_range: assert property (@(posedge clk) disable iff (!rstn)
    cnt <= CNT_W'(DEPTH));

endmodule

// File: doc/uart_rx_fifo_ctl.md
Name: uart_rx_fifo_ctl

Overview:
Parametrised synchronous receive FIFO for the UART RX path, sitting between the RX deserialiser (writer) and the bus/register interface (reader).
Next generation of the RX buffer, adding:
- correct full detection and an occupancy count
- programmable almost-full/almost-empty levels
- sticky overflow/underflow flags
- synchronous flush
- selectable standard or first-word-fall-through (FWFT) read mode

Parameters:
DATA_WIDTH, 8, payload width in bits.
DEPTH, 32, number of entries; power of two, at least 4.
AF_LEVEL, 28, almost_full asserts when count >= AF_LEVEL.
AE_LEVEL, 4, almost_empty asserts when count <= AE_LEVEL.
FWFT, 0, read mode: 0 = registered read; 1 = first-word-fall-through.
CNT_W, $clog2(DEPTH)+1, width of pointers and count (derived; not overridden).

Ports:
clk  in  1  clock; all logic on rising edge.
rstn  in  1  asynchronous, active-low reset.
flush  in  1  synchronous clear of contents.
wr_en  in  1  write request.
wr_data  in  DATA_WIDTH  write payload.
rd_en  in  1  read request.
rd_data  out  DATA_WIDTH  read payload.
full  out  1  count == DEPTH.
empty  out  1  count == 0.
almost_full  out  1  count >= AF_LEVEL.
almost_empty  out  1  count <= AE_LEVEL.
count  out  CNT_W  current occupancy, 0..DEPTH.
overflow  out  1  sticky: write attempted while full.
underflow  out  1  sticky: read attempted while empty.
err_clr  in  1  clears overflow and underflow.

Behaviour:
- Reset (rstn low, asynchronous) clears: wr_ptr, rd_ptr, count, rd_data, overflow, underflow (all 0). Reset state: empty=1, almost_empty=1, full=0, almost_full=0. Memory contents are not reset.
- Pointers are CNT_W bits wide and wrap naturally; the low bits address memory.
- full/empty are decoded from the pointers: equal pointers = empty; MSBs differ with equal low bits = full.
- count is a registered value equal to wr_ptr - rd_ptr (modulo 2^CNT_W). It updates on the same edge as the pointers.
- All flags are combinational from registered pointers/count; they reflect the post-edge state.
- Write accept = wr_en && !full: memory[wr_ptr] <= wr_data, wr_ptr +1.
- Write while full: dropped; data and pointers unchanged; overflow set.
- Read accept = rd_en && !empty: rd_ptr +1. Read while empty: no pointer change; underflow set.
- Simultaneous accepted read and write: both pointers advance; count unchanged.
- When full, a write is refused even if a read is accepted in the same cycle.
- FWFT=0: on an accepted read, rd_data <= memory[rd_ptr], valid from the next cycle. rd_data holds its value otherwise, including across flush.
- FWFT=1: rd_data = memory[rd_ptr] combinationally and is valid whenever empty=0. rd_en acts as a pop. rd_data is don't-care while empty.
- Writing to an empty FIFO: in FWFT mode the word appears on rd_data the cycle after the write edge.
- flush=1: wr_ptr, rd_ptr and count go to 0 on the next edge. flush overrides wr_en/rd_en in that cycle; nothing is written or read. overflow and underflow are not affected.
- err_clr=1 clears both sticky flags. A new error event in the same cycle wins: the flag stays 1.
- Reset mid-operation: immediate return to reset state; any partially accepted transfer is lost.

Optional Feature:
Macro UART_RX_FIFO_ERR_TAG_EN.
Defined:
- Adds input wr_err (1 bit, framing/parity error of the incoming byte) and output rd_err (1 bit).
- Each entry stores the bit alongside its data; rd_err follows exactly the same read timing as rd_data.
- rd_err resets to 0.
Undefined: ports and storage are absent; behaviour is otherwise identical.

Decomposition:
- Shared package uart_pkg holds: default UART_DATA_W=8, UART_RX_FIFO_DEPTH=32, default AF/AE levels, and the function computing CNT_W.
- One natural sub-module: uart_fifo_mem, a simple dual-port register array with synchronous write and asynchronous read.
- Pointer/flag/count logic lives in the top module.

Test Plan:
- Reset, then write 0x01..0x20 (32 words) → full=1, count=32, almost_full from the 28th write. A 33rd write of 0xFF is dropped and sets overflow=1. Reading 32 words returns 0x01..0x20 in order; the 33rd read sets underflow=1.
- FWFT=0: write 0xA5, then pulse rd_en → rd_data=0xA5 one cycle after the rd_en edge; holds 0xA5 with no further reads.
- FWFT=1: write 0x3C to an empty FIFO → rd_data=0x3C and empty=0 the next cycle, before any rd_en.
- Count=10, with wr_en and rd_en asserted together for 50 cycles → count stays 10, data order is preserved, and the pointers wrap at least once.
- Count=20 with overflow=1, then assert flush and err_clr together with wr_en → count=0, empty=1, overflow=0, and no word is written.
- Build with UART_RX_FIFO_ERR_TAG_EN: write (0x55, err=1) then (0x66, err=0) → reads return rd_err 1 then 0, aligned with rd_data. Assert rstn mid-stream → count=0 and rd_err=0 immediately.
